// File: rtl/dds_wave_gen_if.sv
// Selection/tuning inputs and DAC sample outputs of the DDS waveform generator.
// DDS_AMP_SCALE_EN adds the amp_shift control.
interface dds_wave_gen_if #(
   parameter int unsigned PHASE_W = 32
);
   logic [3:0]         wave_select;
   logic [PHASE_W-1:0] freq_word;
   logic               en;
`ifdef DDS_AMP_SCALE_EN
   logic [1:0]         amp_shift;
`endif
   logic [7:0]         dac_data;
   logic               dac_valid;

`ifdef DDS_AMP_SCALE_EN
   modport master (output wave_select, freq_word, en, amp_shift, input dac_data, dac_valid);
   modport slave  (input wave_select, freq_word, en, amp_shift, output dac_data, dac_valid);
`else
   modport master (output wave_select, freq_word, en, input dac_data, dac_valid);
   modport slave  (input wave_select, freq_word, en, output dac_data, dac_valid);
`endif
endinterface

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS: accumulate -> address -> sample, producing an 8-bit unsigned DAC word.
// Optional DDS_AMP_SCALE_EN: arithmetic-shift amplitude scaling about midscale in the sample stage.
module dds_wave_gen #(
   parameter int unsigned PHASE_W      = 32,
   parameter logic [7:0]  PHASE_OFFSET = 8'd0
) (
   input logic           sys_clk,
   input logic           sys_rst_n,
   dds_wave_gen_if.slave bus
);
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned QUART_W = 7;

   // round(127*sin(pi/2*k/64)), k = 0..64
   localparam logic [QUART_W-1:0] QSIN [65] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
      7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
      7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
      7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
      7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
      7'd126, 7'd127, 7'd127, 7'd127, 7'd127
   };

   logic [PHASE_W-1:0] acc;
   logic [3:0]         sel_q;
   logic               en_p1;
   logic [ADDR_W-1:0]  addr;
   logic [3:0]         sel_p2;
   logic               en_p2;
   logic [7:0]         dac_q;
   logic               valid_q;

   logic [QUART_W-1:0] qidx_c;
   logic [QUART_W-1:0] qval_c;
   logic [7:0]         wave_c;
   logic [7:0]         sample_c;

   // Waveform mapping of the stage-2 address; non-one-hot selections park at midscale
   always_comb begin
      qidx_c = addr[6] ? (7'd64 - QUART_W'(addr[5:0])) : QUART_W'(addr[5:0]);
      qval_c = QSIN[qidx_c];
      wave_c = 8'd128;
      case (sel_p2)
         4'b0001: wave_c = addr[7] ? (8'd128 - 8'(qval_c)) : (8'd128 + 8'(qval_c));
         4'b0010: wave_c = addr[7] ? 8'd0 : 8'd255;
         4'b0100: wave_c = addr[7] ? (8'd255 - {addr[6:0], 1'b0}) : {addr[6:0], 1'b0};
         4'b1000: wave_c = addr;
         default: wave_c = 8'd128;
      endcase
   end

`ifdef DDS_AMP_SCALE_EN
   logic signed [8:0] diff_c;
   logic signed [8:0] scaled_c;

   // Scale the excursion from midscale; the sign-preserving shift keeps the result in 0..255
   always_comb begin
      diff_c   = $signed({1'b0, wave_c}) - 9'sd128;
      scaled_c = diff_c >>> bus.amp_shift;
      sample_c = 8'(scaled_c + 9'sd128);
   end
`else
   assign sample_c = wave_c;
`endif

   // A selection change restarts the phase and overrides any increment in that cycle
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         acc     <= '0;
         sel_q   <= 4'b0000;
         en_p1   <= 1'b0;
         addr    <= '0;
         sel_p2  <= 4'b0000;
         en_p2   <= 1'b0;
         dac_q   <= 8'd128;
         valid_q <= 1'b0;
      end else begin
         sel_q <= bus.wave_select;
         en_p1 <= bus.en;
         if (bus.wave_select != sel_q) begin
            acc <= '0;
         end else if (bus.en) begin
            acc <= acc + bus.freq_word;
         end
         addr    <= acc[PHASE_W-1 -: ADDR_W] + PHASE_OFFSET;
         sel_p2  <= sel_q;
         en_p2   <= en_p1;
         dac_q   <= sample_c;
         valid_q <= en_p2;
      end
   end

   assign bus.dac_data  = dac_q;
   assign bus.dac_valid = valid_q;
endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: vector table, directed corner sequences and a
// randomized run against a phase-history reference model.
module tb_dds_wave_gen;
   localparam int unsigned PHASE_W = 32;
   localparam logic [7:0]  OFF     = 8'd0;
   localparam int          AMP     = 2;
   localparam logic [31:0] STEP    = 32'h0100_0000;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   always #10 sys_clk = ~sys_clk;

   dds_wave_gen_if #(.PHASE_W(PHASE_W)) bus ();
   dds_wave_gen #(.PHASE_W(PHASE_W), .PHASE_OFFSET(OFF)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus)
   );

   // Per-edge history of phase, selection and enable; index 0 is the reset state
   logic [31:0] acc_h[$];
   logic [3:0]  sel_h[$];
   logic        en_h[$];
   int nchk = 0;
   int npass = 0;

   typedef struct {
      logic [3:0] sel;
      int         addr;
      int         exp;
   } vec_t;
   vec_t tbl[18];

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int qsine(input int k);
      return int'($floor(127.0 * $sin(3.141592653589793 * real'(k) / 128.0) + 0.5));
   endfunction

   function automatic int scale(input int v);
`ifdef DDS_AMP_SCALE_EN
      return 128 + ((v - 128) >>> AMP);
`else
      return v;
`endif
   endfunction

   function automatic int ref_f(input logic [3:0] sel, input int a);
      int q, i, v;
      q = a / 64;
      i = a % 64;
      case (sel)
         4'b0001: case (q)
                     0:       v = 128 + qsine(i);
                     1:       v = 128 + qsine(64 - i);
                     2:       v = 128 - qsine(i);
                     default: v = 128 - qsine(64 - i);
                  endcase
         4'b0010: v = (a < 128) ? 255 : 0;
         4'b0100: v = (a < 128) ? 2 * a : 255 - 2 * (a - 128);
         4'b1000: v = a;
         default: v = 128;
      endcase
      return scale(v);
   endfunction

   function automatic void model_reset();
      acc_h.delete(); sel_h.delete(); en_h.delete();
      acc_h.push_back(32'd0); sel_h.push_back(4'b0000); en_h.push_back(1'b0);
   endfunction

   // One clock with the given inputs; the model predicts the outputs from the phase two edges back
   task automatic cyc(input logic [3:0] ws, input logic [31:0] fw, input logic e);
      logic [31:0] a;
      logic [7:0]  ad;
      int n, k;
      bus.wave_select = ws;
      bus.freq_word   = fw;
      bus.en          = e;
      @(posedge sys_clk);
      a = acc_h[acc_h.size()-1];
      if (ws != sel_h[sel_h.size()-1]) a = 32'd0;
      else if (e) a = a + fw;
      acc_h.push_back(a); sel_h.push_back(ws); en_h.push_back(e);
      #1;
      n  = acc_h.size() - 1;
      k  = (n >= 2) ? n - 2 : 0;
      ad = acc_h[k][PHASE_W-1 -: 8] + OFF;
      chk("model_dac_data", int'(bus.dac_data), ref_f(sel_h[k], int'(ad)));
      chk("model_dac_valid", int'(bus.dac_valid), (n >= 2) ? int'(en_h[n-2]) : 0);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      bus.wave_select = 4'b0000;
      bus.freq_word   = 32'd0;
      bus.en          = 1'b0;
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      chk("reset_dac_data", int'(bus.dac_data), 128);
      chk("reset_dac_valid", int'(bus.dac_valid), 0);
      #4;
      sys_rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [3:0] ws_list[8];
      logic [3:0] ws;
      logic [31:0] fw;
      logic        e;
      sys_rst_n = 1'b0;
`ifdef DDS_AMP_SCALE_EN
      bus.amp_shift = 2'(AMP);
`endif
      ws_list = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011, 4'b1010, 4'b1111};
      tbl = '{
         '{4'b1000, 0, 0},   '{4'b1000, 200, 200}, '{4'b0010, 127, 255}, '{4'b0010, 128, 0},
         '{4'b0100, 0, 0},   '{4'b0100, 127, 254}, '{4'b0100, 128, 255}, '{4'b0100, 255, 1},
         '{4'b0001, 0, 128}, '{4'b0001, 64, 255},  '{4'b0001, 128, 128}, '{4'b0001, 192, 1},
         '{4'b0001, 32, 218}, '{4'b0001, 96, 218}, '{4'b0001, 160, 38},  '{4'b0001, 1, 131},
         '{4'b0000, 77, 128}, '{4'b0011, 200, 128}
      };

      // Vector table: one increment of addr<<24 lands the phase on the wanted address
      foreach (tbl[t]) begin
         do_reset();
         for (int c = 0; c < 4; c++) cyc(tbl[t].sel, 32'(tbl[t].addr) << 24, 1'b1);
         chk($sformatf("table_%0d_sel%b_addr%0d", t, tbl[t].sel, tbl[t].addr),
             int'(bus.dac_data), scale(tbl[t].exp));
      end

      // Sawtooth from reset release: valid on edge 3, then counting with a 255->0 wrap
      do_reset();
      for (int n = 1; n <= 262; n++) begin
         cyc(4'b1000, STEP, 1'b1);
         if (n <= 2) chk("saw_valid_early", int'(bus.dac_valid), 0);
         else if (n == 3 || n == 4 || n == 258 || n == 259 || n == 260) begin
            chk("saw_valid", int'(bus.dac_valid), 1);
            chk("saw_data", int'(bus.dac_data), scale((n - 3) % 256));
         end
      end

      // Sawtooth -> sine once the phase top byte reaches 0x5A, then the off code
      do_reset();
      for (int n = 1; n <= 91; n++) cyc(4'b1000, STEP, 1'b1);
      cyc(4'b0001, STEP, 1'b1);
      chk("chg_edge92", int'(bus.dac_data), scale(89));
      cyc(4'b0001, STEP, 1'b1);
      chk("chg_edge93", int'(bus.dac_data), scale(90));
      cyc(4'b0001, STEP, 1'b1);
      chk("chg_sine_phase0", int'(bus.dac_data), scale(128));
      cyc(4'b0001, STEP, 1'b1);
      chk("chg_sine_rise", int'(bus.dac_data), scale(131));
      for (int n = 0; n < 8; n++) begin
         cyc(4'b0000, STEP, 1'b1);
         if (n >= 2) chk("off_midscale", int'(bus.dac_data), 128);
      end

      // Enable gap of 10 cycles: output freezes, valid drops, phase resumes without a jump
      do_reset();
      for (int n = 1; n <= 40; n++) begin
         cyc(4'b1000, STEP, (n >= 21 && n <= 30) ? 1'b0 : 1'b1);
         if (n >= 21) begin
            chk("gap_data", int'(bus.dac_data), scale((n <= 22) ? n - 3 : (n <= 32) ? 19 : n - 13));
            chk("gap_valid", int'(bus.dac_valid), (n >= 23 && n <= 32) ? 0 : 1);
         end
      end

      // Randomized run with occasional selection changes and one asynchronous reset
      do_reset();
      ws = 4'b0001;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(7) == 0) ws = ws_list[$urandom_range(7)];
         fw = ($urandom_range(1) == 0) ? $urandom() : (32'($urandom_range(8)) << 24);
         e  = ($urandom_range(3) != 0);
         cyc(ws, fw, e);
         if (n == 300) begin
            #4;
            sys_rst_n = 1'b0;
            #1;
            chk("async_reset_data", int'(bus.dac_data), 128);
            chk("async_reset_valid", int'(bus.dac_valid), 0);
            @(posedge sys_clk);
            #5;
            sys_rst_n = 1'b1;
            model_reset();
         end
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
